// File: rtl/ir_pkg.sv
// Shared NEC infrared definitions: FSM state encoding and frame timing in
// NEC time units. The state encoding is also used by the decoder's debug display.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    REP_SPACE  = 3'd3,
    BIT_MARK   = 3'd4,
    BIT_SPACE  = 3'd5,
    STOP_MARK  = 3'd6,
    GAP        = 3'd7
  } state_t;

  localparam logic [6:0] LEAD_MARK_U  = 7'd16;
  localparam logic [6:0] LEAD_SPACE_U = 7'd8;
  localparam logic [6:0] REP_SPACE_U  = 7'd4;
  localparam logic [6:0] BIT_MARK_U   = 7'd1;
  localparam logic [6:0] ZERO_SPACE_U = 7'd1;
  localparam logic [6:0] ONE_SPACE_U  = 7'd3;
  localparam logic [6:0] STOP_U       = 7'd1;

endpackage

// File: rtl/ir_encoder_if.sv
// Request/status bundle between the command source and the NEC transmitter.
// The master is the command source; the slave is the encoder.
interface ir_encoder_if;

  logic [31:0] code_in;
  logic        valid_in;
  logic        repeat_in;
  logic        ready_out;
  logic        envelope_out;
  logic        ir_out;
  logic        done_out;
  logic [2:0]  state_out;

  modport master (
    output code_in, valid_in, repeat_in,
    input  ready_out, envelope_out, ir_out, done_out, state_out
  );

  modport slave (
    input  code_in, valid_in, repeat_in,
    output ready_out, envelope_out, ir_out, done_out, state_out
  );

endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier square wave for IR modulation. Held in its start state while en_in
// is low, so every rising edge of en_in begins a fresh, high half-period.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 1316
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  output logic carrier_out
);

  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] half_cnt;
  logic          half_low;

  // Half-period counter; toggles phase at the end of each half while enabled.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      half_cnt <= '0;
      half_low <= 1'b0;
    end else if (!en_in) begin
      half_cnt <= '0;
      half_low <= 1'b0;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      half_low <= ~half_low;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  assign carrier_out = en_in & ~half_low;

endmodule

// File: rtl/ir_encoder.sv
// NEC infrared transmitter: sends a 32-bit code MSB first (or a repeat frame)
// as a mark/space envelope, modulated onto a carrier for the IR LED.
module ir_encoder #(
  parameter int UNIT_CYCLES  = 56250,
  parameter int CARRIER_HALF = 1316,
  parameter int GAP_UNITS    = 71
) (
  input logic         clk_in,
  input logic         rst_in,
  ir_encoder_if.slave bus
);

  import ir_pkg::*;

  localparam logic [15:0] UNIT_LAST = 16'(UNIT_CYCLES - 1);
  localparam logic [6:0]  GAP_U     = 7'(GAP_UNITS);

  state_t      state, state_nxt;
  logic [15:0] unit_tmr;
  logic [6:0]  unit_cnt;
  logic [6:0]  phase_units;
  logic [4:0]  bit_cnt;
  logic [31:0] shift_reg;
  logic        rep_frame;
  logic        unit_tick;
  logic        phase_end;
  logic        accept_full;
  logic        accept_rep;
  logic        envelope;
  logic        carrier;

  // A full frame request takes priority over a repeat request.
  assign accept_full = (state == IDLE) && bus.valid_in;
  assign accept_rep  = (state == IDLE) && bus.repeat_in && !bus.valid_in;
  assign unit_tick   = (state != IDLE) && (unit_tmr == UNIT_LAST);
  assign phase_end   = unit_tick && (unit_cnt == phase_units - 7'd1);

  // Length of the current phase in NEC units; a bit's space encodes its value.
  always_comb begin
    phase_units = BIT_MARK_U;
    case (state)
      LEAD_MARK:  phase_units = LEAD_MARK_U;
      LEAD_SPACE: phase_units = LEAD_SPACE_U;
      REP_SPACE:  phase_units = REP_SPACE_U;
      BIT_MARK:   phase_units = BIT_MARK_U;
      BIT_SPACE:  phase_units = shift_reg[31] ? ONE_SPACE_U : ZERO_SPACE_U;
      STOP_MARK:  phase_units = STOP_U;
      GAP:        phase_units = GAP_U;
      default:    phase_units = BIT_MARK_U;
    endcase
  end

  // Next-state decode: phases advance only when their unit count expires.
  always_comb begin
    state_nxt = state;
    envelope  = 1'b0;
    case (state)
      IDLE: begin
        if (accept_full || accept_rep) state_nxt = LEAD_MARK;
      end
      LEAD_MARK: begin
        envelope = 1'b1;
        if (phase_end) state_nxt = rep_frame ? REP_SPACE : LEAD_SPACE;
      end
      LEAD_SPACE: begin
        if (phase_end) state_nxt = BIT_MARK;
      end
      REP_SPACE: begin
        if (phase_end) state_nxt = STOP_MARK;
      end
      BIT_MARK: begin
        envelope = 1'b1;
        if (phase_end) state_nxt = BIT_SPACE;
      end
      BIT_SPACE: begin
        if (phase_end) state_nxt = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: begin
        envelope = 1'b1;
        if (phase_end) state_nxt = GAP;
      end
      GAP: begin
        if (phase_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // Unit timer, per-phase unit counter, bit counter and frame-type flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      unit_tmr  <= '0;
      unit_cnt  <= '0;
      bit_cnt   <= '0;
      rep_frame <= 1'b0;
    end else if (state == IDLE) begin
      unit_tmr <= '0;
      unit_cnt <= '0;
      bit_cnt  <= '0;
      if (accept_full || accept_rep) rep_frame <= accept_rep;
    end else begin
      unit_tmr <= unit_tick ? 16'd0 : unit_tmr + 16'd1;
      if (phase_end)      unit_cnt <= '0;
      else if (unit_tick) unit_cnt <= unit_cnt + 7'd1;
      if (state == BIT_SPACE && phase_end) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Code shift register: loaded on accept, shifted left after each bit's space.
  always_ff @(posedge clk_in) begin
    if (accept_full)                          shift_reg <= bus.code_in;
    else if (state == BIT_SPACE && phase_end) shift_reg <= {shift_reg[30:0], 1'b0};
  end

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_in       (envelope),
    .carrier_out (carrier)
  );

  assign bus.ready_out    = (state == IDLE);
  assign bus.envelope_out = envelope;
  assign bus.ir_out       = envelope & carrier;
  assign bus.done_out     = (state == GAP) && phase_end;
  assign bus.state_out    = state;

endmodule

// File: tb/tb_ir_encoder.sv
// Directed bench for ir_encoder with short timing (10-cycle units,
// 2-cycle carrier halves, 3-unit gap).
module tb_ir_encoder;

  localparam int UC   = 10;
  localparam int CH   = 2;
  localparam int GU   = 3;
  localparam int NMAX = 1400;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ir_encoder_if bus ();

  ir_encoder #(
    .UNIT_CYCLES  (UC),
    .CARRIER_HALF (CH),
    .GAP_UNITS    (GU)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int ncap     = 0;

  logic       env_a  [NMAX+1];
  logic       ir_a   [NMAX+1];
  logic       done_a [NMAX+1];
  logic       rdy_a  [NMAX+1];
  logic [2:0] st_a   [NMAX+1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && bus.ready_out !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check("ready_before_send", {31'd0, bus.ready_out}, 32'd1);
  endtask

  // Issue a request at the next edge and record n cycles after the accept edge.
  // At cycle inj a stray full-frame request is raised for one cycle.
  task automatic send(input logic [31:0] code, input logic v, input logic r,
                      input int n, input int inj);
    wait_ready();
    @(negedge clk);
    bus.code_in   = code;
    bus.valid_in  = v;
    bus.repeat_in = r;
    @(posedge clk);
    #1;
    bus.valid_in  = 1'b0;
    bus.repeat_in = 1'b0;
    bus.code_in   = ~code;
    ncap = n;
    for (int k = 1; k <= n; k++) begin
      env_a[k]  = bus.envelope_out;
      ir_a[k]   = bus.ir_out;
      done_a[k] = bus.done_out;
      rdy_a[k]  = bus.ready_out;
      st_a[k]   = bus.state_out;
      if (k == inj) begin
        bus.code_in  = 32'hFFFF_FFFF;
        bus.valid_in = 1'b1;
      end else if (k == inj + 1) begin
        bus.valid_in = 1'b0;
      end
      if (k < n) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic int last_high();
    int l = 0;
    for (int k = 1; k <= ncap; k++) if (env_a[k] === 1'b1) l = k;
    return l;
  endfunction

  function automatic int high_cnt(input int a, input int b);
    int c = 0;
    for (int k = a; k <= b; k++) if (env_a[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_done();
    for (int k = 1; k <= ncap; k++) if (done_a[k] === 1'b1) return k;
    return 0;
  endfunction

  function automatic int done_n();
    int c = 0;
    for (int k = 1; k <= ncap; k++) if (done_a[k] === 1'b1) c++;
    return c;
  endfunction

  // Rebuild the code from mark/space run lengths: long space = '1', MSB first.
  function automatic logic [31:0] decode();
    int k = 1;
    logic [31:0] v = '0;
    while (k <= ncap && env_a[k] === 1'b1) k++;
    while (k <= ncap && env_a[k] !== 1'b1) k++;
    for (int b = 0; b < 32; b++) begin
      int s = 0;
      while (k <= ncap && env_a[k] === 1'b1) k++;
      while (k <= ncap && env_a[k] !== 1'b1) begin
        s++;
        k++;
      end
      v = {v[30:0], (s > 15)};
    end
    return v;
  endfunction

  // Cycles where ir_out disagrees with a carrier restarted high at each mark.
  function automatic int carrier_bad();
    int bad = 0;
    int pos = 0;
    for (int k = 1; k <= ncap; k++) begin
      if (env_a[k] === 1'b1) begin
        if (ir_a[k] !== (((pos / CH) % 2) == 0)) bad++;
        pos++;
      end else begin
        if (ir_a[k] !== 1'b0) bad++;
        pos = 0;
      end
    end
    return bad;
  endfunction

  initial begin
    int bad;
    bus.code_in   = '0;
    bus.valid_in  = 1'b0;
    bus.repeat_in = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.ready_out}, 32'd1);
    check("rst_env",   {31'd0, bus.envelope_out}, 32'd0);
    check("rst_ir",    {31'd0, bus.ir_out}, 32'd0);
    check("rst_done",  {31'd0, bus.done_out}, 32'd0);
    check("rst_state", {29'd0, bus.state_out}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_out !== 1'b1 || bus.envelope_out !== 1'b0 ||
          bus.ir_out !== 1'b0 || bus.state_out !== 3'd0 || bus.done_out !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);

    // All-zero code
    send(32'h0000_0000, 1'b1, 1'b0, 925, 0);
    check("z_lead_high",   high_cnt(1, 160), 160);
    check("z_lead_space",  high_cnt(161, 240), 0);
    check("z_bit0_mark",   high_cnt(241, 250), 10);
    check("z_bit0_space",  high_cnt(251, 260), 0);
    check("z_last_high",   last_high(), 890);
    check("z_total_high",  high_cnt(1, 925), 490);
    check("z_done_cycle",  first_done(), 920);
    check("z_done_count",  done_n(), 1);
    check("z_rdy_920",     {31'd0, rdy_a[920]}, 32'd0);
    check("z_rdy_921",     {31'd0, rdy_a[921]}, 32'd1);
    check("z_st_1",        {29'd0, st_a[1]}, 32'd1);
    check("z_st_161",      {29'd0, st_a[161]}, 32'd2);
    check("z_st_241",      {29'd0, st_a[241]}, 32'd4);
    check("z_st_251",      {29'd0, st_a[251]}, 32'd5);
    check("z_st_881",      {29'd0, st_a[881]}, 32'd6);
    check("z_st_891",      {29'd0, st_a[891]}, 32'd7);
    check("z_decode",      decode(), 32'h0000_0000);
    check("z_carrier_bad", carrier_bad(), 0);

    // Mixed code, popcount 18
    send(32'h57E3_1EE1, 1'b1, 1'b0, 1285, 0);
    check("m_last_high",   last_high(), 1250);
    check("m_total_high",  high_cnt(1, 1285), 490);
    check("m_done_cycle",  first_done(), 1280);
    check("m_decode",      decode(), 32'h57E3_1EE1);
    check("m_carrier_bad", carrier_bad(), 0);

    // Repeat frame
    send(32'h0000_0000, 1'b0, 1'b1, 245, 0);
    check("r_lead_high",   high_cnt(1, 160), 160);
    check("r_space",       high_cnt(161, 200), 0);
    check("r_stop",        high_cnt(201, 210), 10);
    check("r_last_high",   last_high(), 210);
    check("r_st_161",      {29'd0, st_a[161]}, 32'd3);
    check("r_done_cycle",  first_done(), 240);
    check("r_carrier_bad", carrier_bad(), 0);

    // valid and repeat together: full frame, popcount 5
    send(32'hA500_0001, 1'b1, 1'b1, 1030, 0);
    check("b_st_161",     {29'd0, st_a[161]}, 32'd2);
    check("b_last_high",  last_high(), 990);
    check("b_done_cycle", first_done(), 1020);
    check("b_decode",     decode(), 32'hA500_0001);

    // Stray request mid-frame is dropped
    send(32'h0000_0001, 1'b1, 1'b0, 1200, 300);
    check("i_done_count", done_n(), 1);
    check("i_done_cycle", first_done(), 940);
    check("i_last_high",  last_high(), 910);
    check("i_decode",     decode(), 32'h0000_0001);
    check("i_rdy_end",    {31'd0, rdy_a[1200]}, 32'd1);

    // Reset during the leader mark drops outputs without a clock edge
    send(32'h0F0F_0F0F, 1'b1, 1'b0, 5, 0);
    check("am_env_pre", {31'd0, bus.envelope_out}, 32'd1);
    check("am_ir_pre",  {31'd0, bus.ir_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("am_env",   {31'd0, bus.envelope_out}, 32'd0);
    check("am_ir",    {31'd0, bus.ir_out}, 32'd0);
    check("am_ready", {31'd0, bus.ready_out}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during a bit space, then a clean transmission
    send(32'hFFFF_FFFF, 1'b1, 1'b0, 255, 0);
    check("as_st_pre", {29'd0, bus.state_out}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("as_state", {29'd0, bus.state_out}, 32'd0);
    check("as_env",   {31'd0, bus.envelope_out}, 32'd0);
    check("as_ir",    {31'd0, bus.ir_out}, 32'd0);
    check("as_ready", {31'd0, bus.ready_out}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h1234_5678, 1'b1, 1'b0, 1185, 0);
    check("p_last_high",   last_high(), 1150);
    check("p_done_cycle",  first_done(), 1180);
    check("p_decode",      decode(), 32'h1234_5678);
    check("p_carrier_bad", carrier_bad(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ir_encoder.md
Name: ir_encoder

Overview:
- NEC-format infrared transmitter: serializes a 32-bit code (or an NEC repeat frame) into a mark/space envelope and modulates it onto a 38 kHz carrier to drive an IR LED via a PMOD pin.
- Transmit-side counterpart to ir_decoder; same frame format and bit packing, so a code sent here decodes to the identical 32-bit value.
- Sits in top_level between the command source (switches/buttons or FSM) and the PMOD output pin.

Parameters:
- UNIT_CYCLES, 56250, clock cycles per NEC time unit (562.5 us at 100 MHz); must be ≥2 and <65536.
- CARRIER_HALF, 1316, clock cycles per carrier half-period (~38 kHz at 100 MHz); must be ≥1.
- GAP_UNITS, 71, minimum idle units after a frame before ready_out reasserts (~40 ms); must be ≥1 and ≤127.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  asynchronous, active-low reset
- code_in  input  32  code to send, sampled on accept
- valid_in  input  1  request full frame; accepted when valid_in & ready_out
- repeat_in  input  1  request repeat frame; accepted when repeat_in & ~valid_in & ready_out
- ready_out  output  1  high only in IDLE
- envelope_out  output  1  unmodulated mark (1) / space (0)
- ir_out  output  1  envelope_out AND carrier; drives the LED, active-high
- done_out  output  1  one-cycle pulse on the cycle the gap ends
- state_out  output  3  current FSM state encoding, for LED debug

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, ready_out=1, envelope_out=0, ir_out=0, done_out=0, all counters 0. Assertion mid-frame aborts immediately; outputs go low with no wait for a clock edge.
- Unit timer: 16-bit counter, wraps every UNIT_CYCLES cycles and emits a unit tick. A 7-bit unit counter counts ticks within the current phase. Each phase lasts exactly N*UNIT_CYCLES cycles.
- Accept happens on clock edge t. envelope_out is high from cycle t+1. The code is latched into a 32-bit shift register. Bits are sent MSB first (code_in[31] first), which matches ir_decoder's shift-left assembly.
- Full frame FSM:
  - IDLE → LEAD_MARK (16 units mark) → LEAD_SPACE (8 space) → BIT_MARK (1 mark) → BIT_SPACE (1 space for '0', 3 for '1').
  - Repeat BIT_MARK/BIT_SPACE for 32 bits, tracked by a 5-bit bit counter; after bit 31 go to STOP_MARK (1 mark) → GAP (GAP_UNITS space) → IDLE.
- Repeat frame: IDLE → LEAD_MARK (16) → REP_SPACE (4 space) → STOP_MARK (1) → GAP → IDLE.
- Frame length before GAP:
  - Full frame: 89 + 2*popcount(code) units.
  - Repeat frame: 21 units.
- Simultaneous valid_in and repeat_in: full frame wins. Requests while ready_out=0 are ignored and not queued. code_in changes after accept have no effect.
- done_out pulses on the GAP→IDLE transition cycle. ready_out is high on the following cycle.
- Carrier generator:
  - Restarts at 0 on the first cycle of every mark phase, so the first half-period is high.
  - Toggles every CARRIER_HALF cycles while envelope_out=1 and is held 0 during spaces.
  - ir_out = envelope_out & carrier.
- State encoding for state_out: IDLE=0, LEAD_MARK=1, LEAD_SPACE=2, REP_SPACE=3, BIT_MARK=4, BIT_SPACE=5, STOP_MARK=6, GAP=7.

Decomposition:
- Package ir_pkg:
  - state enum (3-bit, encodings above), shared with ir_decoder debug display.
  - NEC unit constants: LEAD_MARK_U=16, LEAD_SPACE_U=8, REP_SPACE_U=4, BIT_MARK_U=1, ZERO_SPACE_U=1, ONE_SPACE_U=3, STOP_U=1.
- Sub-module ir_carrier_gen (clk_in, rst_in, en_in, carrier_out): resettable half-period counter. It restarts on the rising edge of en_in.

Test Plan (UNIT_CYCLES=10, CARRIER_HALF=2, GAP_UNITS=3):
- Reset with no request: ready_out=1, envelope_out=0, ir_out=0 held indefinitely; state_out=0.
- Send code 32'h00000000:
  - envelope high for cycles 1-160 after accept, low 161-240.
  - 32 × (10 high, 10 low), then 10 high.
  - envelope total 890 cycles; done_out exactly 920 cycles after accept.
- Send 32'h57E31EE1 (popcount 18):
  - frame 125 units = 1250 cycles.
  - captured envelope re-decoded MSB first equals 32'h57E31EE1.
  - ir_out toggles every 2 cycles only inside marks.
- Assert repeat_in with valid_in=0:
  - envelope 160 high, 40 low, 10 high.
  - done_out at cycle 240.
- Timing conflicts:
  - valid_in and repeat_in high together → full frame sent.
  - valid_in pulsed mid-frame → ignored; only one frame observed.
- Drop rst_in low mid BIT_SPACE → ir_out, envelope_out go 0 asynchronously. After release, ready_out=1 and a new code sends cleanly.
